mix_tdm_sched: RTL

MIX_TDM_SCHED -- requirements
Module: mix_tdm_sched

---
 rtl/mix_tdm_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mix_tdm_sched.sv
// rtl/mix_tdm_sched.sv - time-division scheduler sharing one mixer across NRX receiver channels
module mix_tdm_sched #(
    parameter int NRX     = 4,
    parameter int MIX_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adc_valid,
    input  logic            wr_en,
    input  logic [2:0]      wr_addr,
    input  logic [31:0]     wr_data,
    input  logic [NRX-1:0]  ch_en,
    input  logic            phase_clr,
    output logic [31:0]     phi,
    output logic            mix_en,
    output logic            out_valid,
    output logic [2:0]      out_chan,
    output logic            frame_done,
    output logic            overrun
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] LAST_SLOT = 3'(NRX - 1);

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [31:0] phase_q [NRX];
    logic [31:0] phase_d [NRX];
    logic [31:0] freq_q  [NRX];
    logic [31:0] freq_d  [NRX];
    logic [31:0] shd_q   [NRX];
    logic [31:0] shd_d   [NRX];
    logic [31:0] phi_q, phi_d;
    logic        mix_en_q, mix_en_d;
    logic [2:0]  chan_q, chan_d;
    logic        last_q, last_d;
    logic        clr_q, clr_d;
    logic        ovr_q, ovr_d;

    // Slot tag delay line; stage MIX_LAT-1 lines up with the mixer output.
    logic        pv_q [MIX_LAT];
    logic        pv_d [MIX_LAT];
    logic [2:0]  pc_q [MIX_LAT];
    logic [2:0]  pc_d [MIX_LAT];
    logic        pl_q [MIX_LAT];
    logic        pl_d [MIX_LAT];

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        phase_d  = phase_q;
        freq_d   = freq_q;
        shd_d    = shd_q;
        phi_d    = phi_q;
        mix_en_d = 1'b0;
        chan_d   = chan_q;
        last_d   = 1'b0;
        clr_d    = clr_q | phase_clr;
        ovr_d    = ovr_q;

        for (int k = 0; k < NRX; k++) begin
            if (wr_en && wr_addr == 3'(k)) shd_d[k] = wr_data;
        end

        case (state_q)
            IDLE: begin
                if (adc_valid) begin
                    state_d = RUN;
                    slot_d  = 3'd0;
                    // shd_d already holds a write landing on this same edge
                    freq_d  = shd_d;
                    if (clr_d) begin
                        for (int k = 0; k < NRX; k++) phase_d[k] = '0;
                        clr_d = 1'b0;
                    end
                end
            end
            RUN: begin
                if (adc_valid) ovr_d = 1'b1;
                chan_d = slot_q;
                last_d = (slot_q == LAST_SLOT);
                for (int k = 0; k < NRX; k++) begin
                    if (slot_q == 3'(k) && ch_en[k]) begin
                        phi_d      = phase_q[k];
                        mix_en_d   = 1'b1;
                        phase_d[k] = phase_q[k] + freq_q[k];
                    end
                end
                if (slot_q == LAST_SLOT) state_d = IDLE;
                else                     slot_d  = slot_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase

        pv_d[0] = mix_en_q;
        pc_d[0] = chan_q;
        pl_d[0] = last_q;
        for (int i = 1; i < MIX_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pc_d[i] = pc_q[i-1];
            pl_d[i] = pl_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            phi_q    <= '0;
            mix_en_q <= 1'b0;
            chan_q   <= '0;
            last_q   <= 1'b0;
            clr_q    <= 1'b0;
            ovr_q    <= 1'b0;
            for (int k = 0; k < NRX; k++) begin
                phase_q[k] <= '0;
                freq_q[k]  <= '0;
                shd_q[k]   <= '0;
            end
            for (int i = 0; i < MIX_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pc_q[i] <= '0;
                pl_q[i] <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            phi_q    <= phi_d;
            mix_en_q <= mix_en_d;
            chan_q   <= chan_d;
            last_q   <= last_d;
            clr_q    <= clr_d;
            ovr_q    <= ovr_d;
            phase_q  <= phase_d;
            freq_q   <= freq_d;
            shd_q    <= shd_d;
            pv_q     <= pv_d;
            pc_q     <= pc_d;
            pl_q     <= pl_d;
        end
    end

    assign phi        = phi_q;
    assign mix_en     = mix_en_q;
    assign out_valid  = pv_q[MIX_LAT-1];
    assign out_chan   = pc_q[MIX_LAT-1];
    assign frame_done = pl_q[MIX_LAT-1];
    assign overrun    = ovr_q;

endmodule
